// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/busy/done handshake, operands and result of the serial adder.
// The sub select exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master(output start, op_a, op_b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input busy, done, sum, cout);
  modport slave(input start, op_a, op_b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input sub,
`endif
    output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial ripple adder, one full_adder cell stepped LSB first over WIDTH bits.
// Optional subtract mode (op_a - op_b) when SERIAL_ADDER_SUB_EN is defined.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sout,
  output logic cout
);
  assign sout = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(parameter int WIDTH = 8) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic             fa_s, fa_c, sub_w;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = bus.sub;
`else
  assign sub_w = 1'b0;
`endif
  full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .cin(c_q), .sout(fa_s), .cout(fa_c));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      a_d     = bus.op_a;
      b_d     = sub_w ? ~bus.op_b : bus.op_b;
      c_d     = sub_w | bus.cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      ps_d  = {fa_s, ps_q[WIDTH-1:1]};
      c_d   = fa_c;
      cnt_d = cnt_q + 1'b1;
      // final bit: publish the freshly completed sum directly from the shift path
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        sum_d   = {fa_s, ps_q[WIDTH-1:1]};
        cout_d  = fa_c;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    bus.busy = state_q == RUN;
    bus.done = state_q == DONE;
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl (WIDTH=8), covering sub mode when
// SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [W:0] sb[$];
  serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    n_checks++;
    if (bus.busy && bus.done) begin
      n_fail++;
      $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1", bus.busy, bus.done);
    end
  end

  task automatic drive(input logic s, input logic [W-1:0] a, b, input logic c, input logic sb_sel);
    bus.start = s;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sb_sel;
`else
    if (sb_sel) $display("note: sub ignored in add-only build");
`endif
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic c, input logic s);
    return s ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b} + {8'd0, c});
  endfunction

  task automatic do_op(input logic [W-1:0] a, b, input logic c, input logic s, input bit glitch);
    logic [W-1:0] prev;
    logic [W:0]   exp, got;
    int lat;
    sb.push_back(model(a, b, c, s));
    prev = bus.sum;
    @(negedge clk);
    drive(1'b1, a, b, c, s);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 4 * W) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.sum !== prev) begin
        n_fail++;
        $display("FAIL run_hold: busy=%b sum=%h required busy=1 sum=%h", bus.busy, bus.sum, prev);
      end
      if (glitch && lat == 2) drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
      if (glitch && lat == 3) bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != W) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles required %0d", lat, W);
    end
    got = {bus.cout, bus.sum};
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL result a=%h b=%h: got %h required %h", a, b, got, exp);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b required 0", bus.done);
    end
  endtask

  task automatic test_reset;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b cout=%b sum=%h required all 0",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
  endtask

  task automatic test_add;
    do_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
    do_op(8'h3C, 8'h81, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start;
    do_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(1'b1, 8'h0F, 8'hF0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b done=%b cout=%b sum=%h required all 0",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done: done=%b required 0", bus.done);
      end
    end
    rst_n = 1'b1;
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sub;
`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
    do_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
    do_op(8'h40, 8'h10, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] as[3] = '{8'h10, 8'hF0, 8'h80};
    logic [W-1:0] bs[3] = '{8'h20, 8'h20, 8'h80};
    logic         cs[3] = '{1'b0, 1'b1, 1'b0};
    logic [W:0]   exp, got;
    int last, lat;
    last = 0;
    @(negedge clk);
    sb.push_back(model(as[0], bs[0], cs[0], 1'b0));
    drive(1'b1, as[0], bs[0], cs[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      lat = 0;
      @(negedge clk);
      while (!bus.done && lat < 4 * W) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (!bus.done) begin
        n_fail++;
        $display("FAIL b2b_timeout op%0d: no done within %0d cycles", i, 4 * W);
      end
      got = {bus.cout, bus.sum};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b_result op%0d: got %h required %h", i, got, exp);
      end
      if (i > 0) begin
        n_checks++;
        if (cyc - last != W + 2) begin
          n_fail++;
          $display("FAIL b2b_spacing op%0d: got %0d cycles required %0d", i, cyc - last, W + 2);
        end
      end
      last = cyc;
      if (i < 2) begin
        sb.push_back(model(as[i+1], bs[i+1], cs[i+1], 1'b0));
        drive(1'b1, as[i+1], bs[i+1], cs[i+1], 1'b0);
      end else bus.start = 1'b0;
    end
    repeat (2 * W) begin
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_extra_op: busy=%b done=%b required 0 0", bus.busy, bus.done);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_ignore_start;
    test_reset_mid;
    test_sub;
    test_back_to_back;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
